register_file_sb: RTL and testbench

- Parametrised successor to the core's fixed 2-read register file.
- Provides READ_PORTS combinational read ports and one registered writeback port with configurable write-to-read bypass.
- Adds a per-register pending-write scoreboard, so decode can detect RAW hazards against in-flight instructions.
- Sits between decode (reads, issue) and writeback; R0 holds per-core data loaded by the init path.

---
 rtl/register_file_sb_pkg.sv | 11 +
 rtl/register_file_sb_if.sv | 36 +++
 rtl/register_file_scoreboard.sv | 56 +++++
 rtl/register_file_sb.sv | 73 +++++++
 tb/tb_register_file_sb.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/register_file_sb_pkg.sv
// Shared sizing defaults for the register file and its scoreboard.
// Widths derive from REG_COUNT so pointer and array sizes stay consistent.
package register_file_sb_pkg;

    localparam int REG_COUNT_DEF    = 16;
    localparam int REG_SIZE_DEF     = 8;
    localparam int REG_PTR_SIZE_DEF = $clog2(REG_COUNT_DEF);
    localparam int READ_PORTS_DEF   = 2;
    localparam int BYPASS_EN_DEF    = 1;

endpackage

// File: rtl/register_file_sb_if.sv
// Decode/writeback-facing bus of the register file: read ports, hazard
// query, issue notification and writeback. The master side is decode/writeback.
interface register_file_sb_if
    import register_file_sb_pkg::*;
#(
    parameter int REG_SIZE     = REG_SIZE_DEF,
    parameter int REG_PTR_SIZE = REG_PTR_SIZE_DEF,
    parameter int READ_PORTS   = READ_PORTS_DEF
);

    logic                               init_R0;
    logic [REG_SIZE-1:0]                init_R0_data;
    logic [READ_PORTS*REG_PTR_SIZE-1:0] rd_ptr;
    logic [READ_PORTS*REG_SIZE-1:0]     rd_data;
    logic [READ_PORTS-1:0]              rd_pending;
    logic [READ_PORTS-1:0]              rd_used;
    logic                               hazard;
    logic                               issue_valid;
    logic [REG_PTR_SIZE-1:0]            issue_dst;
    logic                               wb_valid;
    logic [REG_PTR_SIZE-1:0]            wb_dst;
    logic [REG_SIZE-1:0]                wb_data;

    modport master (
        output init_R0, init_R0_data, rd_ptr, rd_used,
               issue_valid, issue_dst, wb_valid, wb_dst, wb_data,
        input  rd_data, rd_pending, hazard
    );

    modport slave (
        input  init_R0, init_R0_data, rd_ptr, rd_used,
               issue_valid, issue_dst, wb_valid, wb_dst, wb_data,
        output rd_data, rd_pending, hazard
    );

endinterface

// File: rtl/register_file_scoreboard.sv
// Pending-write scoreboard: one bit per register marking an in-flight producer.
// Issue sets, writeback clears, and a same-cycle issue beats the clear.
module register_file_scoreboard
    import register_file_sb_pkg::*;
#(
    parameter int REG_COUNT    = REG_COUNT_DEF,
    parameter int REG_PTR_SIZE = $clog2(REG_COUNT),
    parameter int READ_PORTS   = READ_PORTS_DEF,
    parameter int BYPASS_EN    = BYPASS_EN_DEF
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_issue_valid,
    input  logic [REG_PTR_SIZE-1:0]            i_issue_dst,
    input  logic                               i_wb_valid,
    input  logic [REG_PTR_SIZE-1:0]            i_wb_dst,
    input  logic [READ_PORTS*REG_PTR_SIZE-1:0] i_rd_ptr,
    output logic [READ_PORTS-1:0]              o_rd_pending
);

    localparam bit BYPASS = (BYPASS_EN != 0);

    logic [REG_COUNT-1:0] r_pend;
    logic [REG_COUNT-1:0] w_pendNext;

    // Set is applied after clear so a newer producer stays outstanding; R0 never pends
    always_comb begin
        w_pendNext = r_pend;
        if (i_wb_valid) begin
            w_pendNext[i_wb_dst] = 1'b0;
        end
        if (i_issue_valid) begin
            w_pendNext[i_issue_dst] = 1'b1;
        end
        w_pendNext[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pendNext;
        end
    end

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_lookup
        logic [REG_PTR_SIZE-1:0] w_ptr;
        logic                    w_wbHit;

        assign w_ptr   = i_rd_ptr[k*REG_PTR_SIZE +: REG_PTR_SIZE];
        // A forwarded writeback makes the operand valid this cycle
        assign w_wbHit = BYPASS && i_wb_valid && (i_wb_dst == w_ptr) && (w_ptr != '0);
        assign o_rd_pending[k] = r_pend[w_ptr] & ~w_wbHit;
    end

endmodule

// File: rtl/register_file_sb.sv
// Multi-port register file with writeback bypass and RAW hazard scoreboard.
// R0 is loaded only through the init path and resets to the core index.
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int CORE_NUM     = 0,
    parameter int REG_COUNT    = REG_COUNT_DEF,
    parameter int REG_SIZE     = REG_SIZE_DEF,
    parameter int REG_PTR_SIZE = $clog2(REG_COUNT),
    parameter int READ_PORTS   = READ_PORTS_DEF,
    parameter int BYPASS_EN    = BYPASS_EN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    register_file_sb_if.slave bus
);

    localparam bit                  BYPASS   = (BYPASS_EN != 0);
    localparam logic [REG_SIZE-1:0] R0_RESET = REG_SIZE'(CORE_NUM);

    logic [REG_SIZE-1:0] r_regs [REG_COUNT];

    // init_R0 is written last so it always owns R0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_regs[0] <= R0_RESET;
            for (int i = 1; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (bus.wb_valid && (bus.wb_dst != '0)) begin
                r_regs[bus.wb_dst] <= bus.wb_data;
            end
            if (bus.init_R0) begin
                r_regs[0] <= bus.init_R0_data;
            end
        end
    end

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_read
        logic [REG_PTR_SIZE-1:0] w_ptr;
        logic                    w_fwdWb;
        logic                    w_fwdInit;

        assign w_ptr     = bus.rd_ptr[k*REG_PTR_SIZE +: REG_PTR_SIZE];
        assign w_fwdWb   = BYPASS && bus.wb_valid && (bus.wb_dst == w_ptr) && (w_ptr != '0);
        assign w_fwdInit = BYPASS && bus.init_R0 && (w_ptr == '0);

        assign bus.rd_data[k*REG_SIZE +: REG_SIZE] =
            w_fwdInit ? bus.init_R0_data :
            w_fwdWb   ? bus.wb_data      :
                        r_regs[w_ptr];
    end

    register_file_scoreboard #(
        .REG_COUNT   (REG_COUNT),
        .REG_PTR_SIZE(REG_PTR_SIZE),
        .READ_PORTS  (READ_PORTS),
        .BYPASS_EN   (BYPASS_EN)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .i_issue_valid(bus.issue_valid),
        .i_issue_dst  (bus.issue_dst),
        .i_wb_valid   (bus.wb_valid),
        .i_wb_dst     (bus.wb_dst),
        .i_rd_ptr     (bus.rd_ptr),
        .o_rd_pending (bus.rd_pending)
    );

    assign bus.hazard = |(bus.rd_used & bus.rd_pending);

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: a bypassing and a non-bypassing copy
// share one stimulus stream so forwarding differences show side by side.
module tb_register_file_sb;

    logic clk;
    logic reset;
    int   errorCount;
    int   checkCount;

    register_file_sb_if #(.REG_SIZE(8), .REG_PTR_SIZE(4), .READ_PORTS(2)) busA ();
    register_file_sb_if #(.REG_SIZE(8), .REG_PTR_SIZE(4), .READ_PORTS(2)) busB ();

    register_file_sb #(
        .CORE_NUM(3), .REG_COUNT(16), .REG_SIZE(8), .REG_PTR_SIZE(4),
        .READ_PORTS(2), .BYPASS_EN(1)
    ) dutA (
        .clk  (clk),
        .reset(reset),
        .bus  (busA.slave)
    );

    register_file_sb #(
        .CORE_NUM(3), .REG_COUNT(16), .REG_SIZE(8), .REG_PTR_SIZE(4),
        .READ_PORTS(2), .BYPASS_EN(0)
    ) dutB (
        .clk  (clk),
        .reset(reset),
        .bus  (busB.slave)
    );

    // The non-bypassing copy mirrors every input of the bypassing one
    assign busB.init_R0      = busA.init_R0;
    assign busB.init_R0_data = busA.init_R0_data;
    assign busB.rd_ptr       = busA.rd_ptr;
    assign busB.rd_used      = busA.rd_used;
    assign busB.issue_valid  = busA.issue_valid;
    assign busB.issue_dst    = busA.issue_dst;
    assign busB.wb_valid     = busA.wb_valid;
    assign busB.wb_dst       = busA.wb_dst;
    assign busB.wb_data      = busA.wb_data;

    initial begin
        clk = 1'b0;
        #20;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(
        input logic [3:0] p0, input logic [3:0] p1, input logic [1:0] used,
        input logic iv, input logic [3:0] idst,
        input logic wv, input logic [3:0] wdst, input logic [7:0] wdata,
        input logic ini, input logic [7:0] idata);
        busA.rd_ptr       = {p1, p0};
        busA.rd_used      = used;
        busA.issue_valid  = iv;
        busA.issue_dst    = idst;
        busA.wb_valid     = wv;
        busA.wb_dst       = wdst;
        busA.wb_data      = wdata;
        busA.init_R0      = ini;
        busA.init_R0_data = idata;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errorCount = 0;
        checkCount = 0;
        reset = 1'b1;
        applyStimulus(4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);

        // Asynchronous reset with no clock edge yet
        reset = 1'b0;
        for (int p = 0; p < 16; p++) begin
            logic [3:0] ptr;
            ptr = p[3:0];
            applyStimulus(ptr, ptr, 2'b11, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
            checkOutput($sformatf("rst_r%0d", p), {24'd0, busA.rd_data[7:0]},
                        (p == 0) ? 32'd3 : 32'd0);
        end
        checkOutput("rst_hazard",  {31'd0, busA.hazard}, 32'd0);
        checkOutput("rst_pending", {30'd0, busA.rd_pending}, 32'd0);
        reset = 1'b1;

        // Writeback to r5: forwarded same cycle only with bypass
        applyStimulus(4'd5, 4'd0, 2'b00, 1'b0, 4'd0, 1'b1, 4'd5, 8'hA5, 1'b0, 8'h00);
        checkOutput("wb_byp_same",   {24'd0, busA.rd_data[7:0]},  32'hA5);
        checkOutput("wb_nobyp_same", {24'd0, busB.rd_data[7:0]},  32'h00);
        checkOutput("wb_r0_port1",   {24'd0, busA.rd_data[15:8]}, 32'h03);
        nextCycle();
        applyStimulus(4'd5, 4'd0, 2'b00, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
        checkOutput("wb_byp_next",   {24'd0, busA.rd_data[7:0]}, 32'hA5);
        checkOutput("wb_nobyp_next", {24'd0, busB.rd_data[7:0]}, 32'hA5);

        // Issue to r7, then three stalled cycles, then writeback
        applyStimulus(4'd0, 4'd7, 2'b10, 1'b1, 4'd7, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
        checkOutput("sb_issue_cyc", {31'd0, busA.hazard}, 32'd0);
        for (int c = 1; c <= 3; c++) begin
            nextCycle();
            applyStimulus(4'd0, 4'd7, 2'b10, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
            checkOutput($sformatf("sb_hazard_c%0d", c), {31'd0, busA.hazard}, 32'd1);
            checkOutput($sformatf("sb_pend_c%0d", c), {30'd0, busA.rd_pending}, 32'b10);
        end
        nextCycle();
        applyStimulus(4'd0, 4'd7, 2'b10, 1'b0, 4'd0, 1'b1, 4'd7, 8'h33, 1'b0, 8'h00);
        checkOutput("sb_wb_byp_haz",   {31'd0, busA.hazard}, 32'd0);
        checkOutput("sb_wb_nobyp_haz", {31'd0, busB.hazard}, 32'd1);
        nextCycle();
        applyStimulus(4'd0, 4'd7, 2'b10, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
        checkOutput("sb_after_haz_a", {31'd0, busA.hazard}, 32'd0);
        checkOutput("sb_after_haz_b", {31'd0, busB.hazard}, 32'd0);
        checkOutput("sb_after_data",  {24'd0, busA.rd_data[15:8]}, 32'h33);

        // Issue and writeback to r2 in the same cycle: the set wins
        applyStimulus(4'd2, 4'd0, 2'b01, 1'b1, 4'd2, 1'b1, 4'd2, 8'h11, 1'b0, 8'h00);
        checkOutput("sim_pend_same", {30'd0, busA.rd_pending}, 32'b00);
        nextCycle();
        applyStimulus(4'd2, 4'd0, 2'b01, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
        checkOutput("sim_data",   {24'd0, busA.rd_data[7:0]}, 32'h11);
        checkOutput("sim_pend",   {30'd0, busA.rd_pending}, 32'b01);
        checkOutput("sim_hazard", {31'd0, busA.hazard}, 32'd1);

        // R0 ignores writeback; init_R0 loads it and is forwarded with bypass
        applyStimulus(4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 1'b1, 4'd0, 8'hFF, 1'b0, 8'h00);
        checkOutput("r0_wb_same", {24'd0, busA.rd_data[7:0]}, 32'h03);
        nextCycle();
        applyStimulus(4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
        checkOutput("r0_wb_next", {24'd0, busA.rd_data[7:0]}, 32'h03);
        applyStimulus(4'd0, 4'd0, 2'b01, 1'b1, 4'd0, 1'b1, 4'd0, 8'hFF, 1'b1, 8'h42);
        checkOutput("r0_init_byp",   {24'd0, busA.rd_data[7:0]}, 32'h42);
        checkOutput("r0_init_nobyp", {24'd0, busB.rd_data[7:0]}, 32'h03);
        nextCycle();
        applyStimulus(4'd0, 4'd0, 2'b01, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
        checkOutput("r0_init_a",   {24'd0, busA.rd_data[7:0]}, 32'h42);
        checkOutput("r0_init_b",   {24'd0, busB.rd_data[7:0]}, 32'h42);
        checkOutput("r0_pend",     {30'd0, busA.rd_pending}, 32'b00);
        checkOutput("r0_hazard",   {31'd0, busA.hazard}, 32'd0);

        // Pending r4 holding 9, hazard masking, then reset between edges
        applyStimulus(4'd0, 4'd0, 2'b00, 1'b1, 4'd4, 1'b1, 4'd4, 8'h09, 1'b0, 8'h00);
        nextCycle();
        applyStimulus(4'd4, 4'd4, 2'b00, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
        checkOutput("ar_data",        {24'd0, busA.rd_data[7:0]}, 32'h09);
        checkOutput("ar_pend",        {30'd0, busA.rd_pending}, 32'b11);
        checkOutput("ar_masked_haz",  {31'd0, busA.hazard}, 32'd0);
        applyStimulus(4'd4, 4'd2, 2'b01, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
        checkOutput("ar_used_haz",    {31'd0, busA.hazard}, 32'd1);
        checkOutput("ar_pend_r2",     {30'd0, busA.rd_pending}, 32'b11);
        reset = 1'b0;
        #1;
        checkOutput("ar_rst_data",    {24'd0, busA.rd_data[7:0]}, 32'h00);
        checkOutput("ar_rst_pend",    {30'd0, busA.rd_pending}, 32'b00);
        checkOutput("ar_rst_hazard",  {31'd0, busA.hazard}, 32'd0);
        applyStimulus(4'd4, 4'd0, 2'b11, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
        checkOutput("ar_rst_r0",      {24'd0, busA.rd_data[15:8]}, 32'h03);
        reset = 1'b1;
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
